// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 active-low matrix keypad scanner with synchroniser,
// press/release debounce and key decode.
// Optional feature: define KEYPAD_MULTI_REJECT_EN to reject multi-row presses
// instead of letting the lowest-index low row win.
module keypad_scanner #(
   parameter int unsigned SCAN_DIV     = 4,
   parameter int unsigned DEBOUNCE_CYC = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [3:0] row_n,
   output logic [3:0] col_n,
   output logic [3:0] key_value,
   output logic [2:0] is_sign_key,
   output logic       key_pressed,
   output logic       key_strobe
);

   localparam int unsigned DW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int unsigned DBW = $clog2(DEBOUNCE_CYC + 1);

   typedef enum logic [1:0] {
      SCAN,
      DEB_PRESS,
      PRESSED,
      DEB_RELEASE
   } state_t;

   state_t         state;
   logic [3:0]     row_s1, row_s2;
   logic [1:0]     col_idx, nxt_col, cap_row, first_row;
   logic [DW-1:0]  div_cnt;
   logic [DBW-1:0] deb_cnt;
   logic [3:0]     row_low;
   logic           any_low, cap_low, sample_reject, deb_reject;
   logic [3:0]     dec_val;
   logic [2:0]     dec_sign;

   // two-flop synchroniser for the asynchronous row inputs; idles released
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         row_s1 <= '1;
         row_s2 <= '1;
      end else begin
         row_s1 <= row_n;
         row_s2 <= row_s1;
      end
   end

   // row status, lowest-index low row and multi-press qualification
   always_comb begin
      row_low   = ~row_s2;
      any_low   = |row_low;
      cap_low   = row_low[cap_row];
      nxt_col   = col_idx + 2'd1;
      first_row = 2'd0;
      for (int i = 3; i >= 0; i--) begin
         if (row_low[i]) first_row = 2'(i);
      end
`ifdef KEYPAD_MULTI_REJECT_EN
      sample_reject = (row_low & (row_low - 4'd1)) != 4'd0;
      deb_reject    = (row_low & ~(4'b0001 << cap_row)) != 4'd0;
`else
      sample_reject = 1'b0;
      deb_reject    = 1'b0;
`endif
   end

   // keymap decode of the captured (row, column) pair
   always_comb begin
      dec_val  = 4'h0;
      dec_sign = 3'b000;
      case ({cap_row, col_idx})
         4'b00_00: dec_val = 4'h1;
         4'b00_01: dec_val = 4'h2;
         4'b00_10: dec_val = 4'h3;
         4'b00_11: begin dec_val = 4'hA; dec_sign = 3'b010; end
         4'b01_00: dec_val = 4'h4;
         4'b01_01: dec_val = 4'h5;
         4'b01_10: dec_val = 4'h6;
         4'b01_11: begin dec_val = 4'hB; dec_sign = 3'b100; end
         4'b10_00: dec_val = 4'h7;
         4'b10_01: dec_val = 4'h8;
         4'b10_10: dec_val = 4'h9;
         4'b10_11: begin dec_val = 4'hC; dec_sign = 3'b111; end
         4'b11_00: begin dec_val = 4'hE; dec_sign = 3'b001; end
         4'b11_01: dec_val = 4'h0;
         4'b11_10: begin dec_val = 4'hF; dec_sign = 3'b111; end
         default:  begin dec_val = 4'hD; dec_sign = 3'b111; end
      endcase
   end

   // scan / debounce FSM with registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state       <= SCAN;
         col_idx     <= 2'd0;
         col_n       <= 4'b1110;
         cap_row     <= 2'd0;
         div_cnt     <= '0;
         deb_cnt     <= '0;
         key_value   <= '0;
         is_sign_key <= '0;
         key_pressed <= 1'b0;
         key_strobe  <= 1'b0;
      end else begin
         key_strobe <= 1'b0;
         case (state)
            SCAN: begin
               if (div_cnt == DW'(SCAN_DIV - 1)) begin
                  div_cnt <= '0;
                  if (any_low && !sample_reject) begin
                     cap_row <= first_row;
                     deb_cnt <= '0;
                     state   <= DEB_PRESS;
                  end else begin
                     col_idx <= nxt_col;
                     col_n   <= ~(4'b0001 << nxt_col);
                  end
               end else begin
                  div_cnt <= div_cnt + 1'b1;
               end
            end
            DEB_PRESS: begin
               if (!cap_low || deb_reject) begin
                  div_cnt <= '0;
                  state   <= SCAN;
               end else if (deb_cnt == DBW'(DEBOUNCE_CYC)) begin
                  key_value   <= dec_val;
                  is_sign_key <= dec_sign;
                  key_pressed <= 1'b1;
                  key_strobe  <= 1'b1;
                  state       <= PRESSED;
               end else begin
                  deb_cnt <= deb_cnt + 1'b1;
               end
            end
            PRESSED: begin
               if (!cap_low) begin
                  deb_cnt <= '0;
                  state   <= DEB_RELEASE;
               end
            end
            default: begin
               if (cap_low) begin
                  state <= PRESSED;
               end else if (deb_cnt == DBW'(DEBOUNCE_CYC - 1)) begin
                  key_pressed <= 1'b0;
                  div_cnt     <= '0;
                  col_idx     <= nxt_col;
                  col_n       <= ~(4'b0001 << nxt_col);
                  state       <= SCAN;
               end else begin
                  deb_cnt <= deb_cnt + 1'b1;
               end
            end
         endcase
      end
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: keypad model driving row_n from col_n, table of all keys,
// plus reset, bounce, glitch, multi-key and reset-during-press sequences.
module tb_keypad_scanner;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] row_n;
   logic [3:0] col_n;
   logic [3:0] key_value;
   logic [2:0] is_sign_key;
   logic       key_pressed;
   logic       key_strobe;

   logic [15:0] held;
   logic [3:0]  force_low;

   int tests = 0;
   int fails = 0;
   int n_strobe = 0;
   int n_rise = 0;
   logic prev_strobe = 1'b0;
   logic prev_pressed = 1'b0;

   typedef struct packed {
      logic [3:0] v;
      logic [2:0] s;
   } exp_t;
   exp_t exp_q[$];

   typedef struct {
      int         row;
      int         col;
      logic [3:0] val;
      logic [2:0] sign;
   } vec_t;
   vec_t vecs[16];

   keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_CYC(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .row_n       (row_n),
      .col_n       (col_n),
      .key_value   (key_value),
      .is_sign_key (is_sign_key),
      .key_pressed (key_pressed),
      .key_strobe  (key_strobe)
   );

   always #5 clk = ~clk;

   // keypad matrix: a held key pulls its row low while its column is driven
   always_comb begin
      row_n = 4'hF;
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < 4; c++) begin
            if (held[r*4+c] && !col_n[c]) row_n[r] = 1'b0;
         end
         if (force_low[r]) row_n[r] = 1'b0;
      end
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // strobe monitor / scoreboard consumer
   always @(negedge clk) begin
      if (rst !== 1'b1) begin
         prev_strobe  = 1'b0;
         prev_pressed = 1'b0;
      end else begin
         if (key_strobe) begin
            n_strobe++;
            check("strobe_one_cycle", prev_strobe, 1'b0);
            check("strobe_on_rise", {key_pressed, prev_pressed}, 2'b10);
            if (exp_q.size() == 0) begin
               tests++;
               fails++;
               $display("FAIL unexpected_strobe: got key %0h sign %b expected none", key_value, is_sign_key);
            end else begin
               exp_t e;
               e = exp_q.pop_front();
               check("sb_key_value", key_value, e.v);
               check("sb_sign", is_sign_key, e.s);
            end
         end
         if (key_pressed && !prev_pressed) n_rise++;
         prev_strobe  = key_strobe;
         prev_pressed = key_pressed;
      end
   end

   task automatic run_key(input string name, input logic [15:0] mask, input bit hit,
                          input logic [3:0] v, input logic [2:0] s);
      int s0, r0;
      logic [3:0] kv0;
      logic [2:0] ks0;
      s0  = n_strobe;
      r0  = n_rise;
      kv0 = key_value;
      ks0 = is_sign_key;
      if (hit) exp_q.push_back('{v: v, s: s});
      held = mask;
      if (hit) begin
         for (int i = 0; i < 80 && key_pressed !== 1'b1; i++) tick();
         check({name, "_pressed"}, key_pressed, 1'b1);
         repeat (20) tick();
         held = '0;
         for (int i = 0; i < 40 && key_pressed !== 1'b0; i++) tick();
         check({name, "_released"}, key_pressed, 1'b0);
         repeat (4) tick();
         check({name, "_value_held"}, key_value, v);
         check({name, "_sign_held"}, is_sign_key, s);
      end else begin
         repeat (60) tick();
         check({name, "_no_press"}, key_pressed, 1'b0);
         held = '0;
         repeat (30) tick();
         check({name, "_value_kept"}, key_value, kv0);
         check({name, "_sign_kept"}, is_sign_key, ks0);
      end
      check({name, "_strobes"}, n_strobe - s0, hit ? 1 : 0);
      check({name, "_rises"}, n_rise - r0, hit ? 1 : 0);
   endtask

   task automatic check_reset_outputs(input string name);
      check({name, "_col"}, col_n, 4'b1110);
      check({name, "_val"}, key_value, 4'h0);
      check({name, "_sign"}, is_sign_key, 3'b000);
      check({name, "_pressed"}, key_pressed, 1'b0);
      check({name, "_strobe"}, key_strobe, 1'b0);
   endtask

   task automatic check_col_advance(input string name);
      @(negedge clk);
      rst = 1'b1;
      repeat (3) tick();
      check({name, "_hold"}, col_n, 4'b1110);
      tick();
      check({name, "_step"}, col_n, 4'b1101);
   endtask

   initial begin
      vecs[0]  = '{0, 0, 4'h1, 3'b000};
      vecs[1]  = '{0, 1, 4'h2, 3'b000};
      vecs[2]  = '{0, 2, 4'h3, 3'b000};
      vecs[3]  = '{0, 3, 4'hA, 3'b010};
      vecs[4]  = '{1, 0, 4'h4, 3'b000};
      vecs[5]  = '{1, 1, 4'h5, 3'b000};
      vecs[6]  = '{1, 2, 4'h6, 3'b000};
      vecs[7]  = '{1, 3, 4'hB, 3'b100};
      vecs[8]  = '{2, 0, 4'h7, 3'b000};
      vecs[9]  = '{2, 1, 4'h8, 3'b000};
      vecs[10] = '{2, 2, 4'h9, 3'b000};
      vecs[11] = '{2, 3, 4'hC, 3'b111};
      vecs[12] = '{3, 0, 4'hE, 3'b001};
      vecs[13] = '{3, 1, 4'h0, 3'b000};
      vecs[14] = '{3, 2, 4'hF, 3'b111};
      vecs[15] = '{3, 3, 4'hD, 3'b111};

      rst       = 1'b0;
      held      = '0;
      force_low = '0;
      repeat (3) tick();
      check_reset_outputs("por");
      check_col_advance("col_adv");

      // asynchronous reset mid-scan
      repeat (6) tick();
      #2 rst = 1'b0;
      #1 check_reset_outputs("async_rst");
      repeat (2) tick();
      check_col_advance("col_adv2");

      // every key of the matrix
      for (int k = 0; k < 16; k++) begin
         logic [15:0] m;
         m = '0;
         m[vecs[k].row*4 + vecs[k].col] = 1'b1;
         run_key($sformatf("key_r%0dc%0d", vecs[k].row, vecs[k].col), m, 1'b1,
                 vecs[k].val, vecs[k].sign);
         repeat (5) tick();
      end

      // B, *, # in sequence
      run_key("seq_B", 16'h0080, 1'b1, 4'hB, 3'b100);
      run_key("seq_star", 16'h1000, 1'b1, 4'hE, 3'b001);
      run_key("seq_hash", 16'h4000, 1'b1, 4'hF, 3'b111);

      // bouncing contact on 'A', then a clean hold
      for (int i = 0; i < 7; i++) begin
         held = (i % 2 == 0) ? 16'h0008 : 16'h0000;
         repeat (3) tick();
      end
      run_key("bounce_A", 16'h0008, 1'b1, 4'hA, 3'b010);

      // short glitch on r2 while column 0 is driven
      begin
         int s0;
         logic [3:0] kv0;
         s0  = n_strobe;
         kv0 = key_value;
         for (int i = 0; i < 40 && col_n !== 4'b1110; i++) tick();
         check("glitch_col0", col_n, 4'b1110);
         force_low[2] = 1'b1;
         repeat (5) tick();
         force_low[2] = 1'b0;
         repeat (20) tick();
         check("glitch_strobes", n_strobe - s0, 0);
         check("glitch_value", key_value, kv0);
         check("glitch_pressed", key_pressed, 1'b0);
         for (int i = 0; i < 40 && col_n !== 4'b1101; i++) tick();
         check("glitch_scan_resume", col_n, 4'b1101);
      end

      // r1 and r2 held together in column 0
`ifdef KEYPAD_MULTI_REJECT_EN
      run_key("multi", 16'h0110, 1'b0, 4'h0, 3'b000);
`else
      run_key("multi", 16'h0110, 1'b1, 4'h4, 3'b000);
`endif

      // reset while a key is accepted
      exp_q.push_back('{v: 4'h5, s: 3'b000});
      held = 16'h0020;
      for (int i = 0; i < 80 && key_pressed !== 1'b1; i++) tick();
      check("rst_press_pressed", key_pressed, 1'b1);
      repeat (5) tick();
      #2 rst = 1'b0;
      #1;
      check("rst_press_abort", key_pressed, 1'b0);
      check("rst_press_val", key_value, 4'h0);
      check("rst_press_col", col_n, 4'b1110);
      held = '0;
      repeat (3) tick();
      @(negedge clk);
      rst = 1'b1;
      repeat (40) tick();
      check("rst_press_idle", key_pressed, 1'b0);

      check("sb_empty", exp_q.size(), 0);
      check("rise_eq_strobe", n_rise, n_strobe);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
